// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start/data/optional parity/stop, LSB first.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error
);

    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BitW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    sampled_bit_q, sampled_bit_d;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q, par_err_d;
    logic                    stop_err_q, stop_err_d;
`ifdef UART_RX_MAJORITY_EN
    logic                    samp_a_q, samp_a_d;
    logic                    samp_b_q, samp_b_d;
`endif

    logic [PRESCALE_W-1:0]   half;
    logic                    last_edge;
    logic                    sample_pt;
    logic                    in_frame;

    // Frame timing uses the Prescale captured at start, not the live input.
    assign half      = prescale_q >> 1;
    assign last_edge = (edge_cnt_q == prescale_q - 1'b1);
    assign sample_pt = (edge_cnt_q == half + 1'b1);
    assign in_frame  = (state_q != StIdle);

    always_comb begin
        state_d       = state_q;
        edge_cnt_d    = edge_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        sampled_bit_d = sampled_bit_q;
        prescale_d    = prescale_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        p_data_d      = p_data_q;
        data_valid_d  = 1'b0;
        par_err_d     = par_err_q;
        stop_err_d    = stop_err_q;
`ifdef UART_RX_MAJORITY_EN
        samp_a_d      = samp_a_q;
        samp_b_d      = samp_b_q;
`endif

        if (!in_frame) begin
            edge_cnt_d = '0;
        end else if (last_edge) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end

        if (in_frame) begin
`ifdef UART_RX_MAJORITY_EN
            if (edge_cnt_q == half - 1'b1) begin
                samp_a_d = RX_IN;
            end
            if (edge_cnt_q == half) begin
                samp_b_d = RX_IN;
            end
            if (sample_pt) begin
                sampled_bit_d = (samp_a_q & samp_b_q) | (samp_a_q & RX_IN) | (samp_b_q & RX_IN);
            end
`else
            if (sample_pt) begin
                sampled_bit_d = RX_IN;
            end
`endif
        end

        case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (!RX_IN) begin
                    state_d    = StStart;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_err_d  = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            StStart: begin
                if (last_edge) begin
                    state_d = sampled_bit_q ? StIdle : StData;
                end
            end
            StData: begin
                if (last_edge) begin
                    shift_d[bit_cnt_q] = sampled_bit_q;
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (last_edge) begin
                    par_err_d = (sampled_bit_q != (^shift_q ^ par_typ_q));
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (last_edge) begin
                    stop_err_d = !sampled_bit_q;
                    state_d    = StIdle;
                    if (sampled_bit_q && !par_err_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= StIdle;
            edge_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            sampled_bit_q <= 1'b0;
            prescale_q    <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stop_err_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            samp_a_q      <= 1'b0;
            samp_b_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            sampled_bit_q <= sampled_bit_d;
            prescale_q    <= prescale_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            p_data_q      <= p_data_d;
            data_valid_q  <= data_valid_d;
            par_err_q     <= par_err_d;
            stop_err_q    <= stop_err_d;
`ifdef UART_RX_MAJORITY_EN
            samp_a_q      <= samp_a_d;
            samp_b_q      <= samp_b_d;
`endif
        end
    end

    assign P_DATA       = p_data_q;
    assign Data_Valid   = data_valid_q;
    assign Parity_Error = par_err_q;
    assign Stop_Error   = stop_err_q;

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have parameter PRESCALE_W, default 6, giving the width of Prescale and the edge counter.
REQ-003 CLK  input  1  oversampling clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 RX_IN  input  1  serial line; idle high; already synchronised to CLK.
REQ-006 Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32; other values give undefined results.
REQ-007 PAR_EN  input  1  1 = a parity bit follows the data bits.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 P_DATA  output  DATA_WIDTH  last frame received without errors.
REQ-010 Data_Valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-011 Parity_Error  output  1  parity mismatch in the most recent frame.
REQ-012 Stop_Error  output  1  stop bit sampled 0 in the most recent frame.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-014 Frame format SHALL be: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
REQ-015 In IDLE, edge_cnt and bit_cnt SHALL be held at 0; RX_IN==0 SHALL cause the move to START.
REQ-016 In START/DATA/PARITY/STOP, edge_cnt SHALL increment every cycle from 0 to Prescale-1, then wrap to 0; edge_cnt==Prescale-1 marks end-of-bit.
REQ-017 The bit value SHALL be resolved at edge_cnt==Prescale/2+1 (see REQ-031/032) and registered as sampled_bit.
REQ-018 START at end-of-bit: sampled_bit==0 -> DATA; sampled_bit==1 -> IDLE (glitch rejected, no flag or output changes).
REQ-019 DATA: at end-of-bit, sampled_bit SHALL shift into position bit_cnt of the shift register and bit_cnt SHALL increment; after bit DATA_WIDTH-1, go to PARITY if PAR_EN, else STOP, with bit_cnt cleared.
REQ-020 PARITY at end-of-bit: Parity_Error SHALL be set to (sampled_bit != XOR(data) ^ PAR_TYP); next state STOP.
REQ-021 STOP at end-of-bit: Stop_Error SHALL be set to !sampled_bit; next state IDLE.
REQ-022 If Stop_Error and Parity_Error are both 0 after STOP, P_DATA SHALL load the shift register and Data_Valid SHALL be 1 for exactly the first IDLE cycle; otherwise P_DATA is unchanged and Data_Valid stays 0.
REQ-023 Parity_Error and Stop_Error SHALL hold until the next IDLE->START transition, where both SHALL clear.
REQ-024 Start detection SHALL be active in the same IDLE cycle that carries Data_Valid, so back-to-back frames are received with no gap cycle.
REQ-025 PAR_EN, PAR_TYP and Prescale SHALL be sampled only on IDLE->START; changes mid-frame SHALL NOT affect the frame in progress.
REQ-026 RX_IN going low during DATA, PARITY or STOP SHALL NOT restart the frame.

Reset
REQ-027 On RST low, state SHALL be IDLE and edge_cnt, bit_cnt, shift register and sampled_bit SHALL be 0.
REQ-028 On RST low, P_DATA SHALL be 0 and Data_Valid, Parity_Error and Stop_Error SHALL be 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first falling edge after release SHALL start a new frame.
REQ-030 Reset release SHALL be glitch-free for Data_Valid: no pulse in the first cycle after release.

Configuration
REQ-031 With UART_RX_MAJORITY_EN defined, the block SHALL sample RX_IN at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1, and sampled_bit SHALL be the 2-of-3 majority.
REQ-032 Without UART_RX_MAJORITY_EN, sampled_bit SHALL be RX_IN at edge_cnt==Prescale/2+1 only; all other behaviour is identical.

Verification
REQ-033 Prescale=8, PAR_EN=0, frame 0xA5 -> exactly one Data_Valid pulse, P_DATA=0xA5, Parity_Error=0, Stop_Error=0.
REQ-034 Prescale=16, PAR_EN=1, PAR_TYP=0, 0x37 with correct even parity bit 1 -> P_DATA=0x37; repeat with parity bit 0 -> Parity_Error=1, no Data_Valid, P_DATA still 0x37.
REQ-035 Prescale=32, frame 0x5A with stop bit 0 -> Stop_Error=1, no Data_Valid; next correct frame 0x0F clears Stop_Error at its start and pulses Data_Valid with P_DATA=0x0F.
REQ-036 RX_IN low for 3 cycles at Prescale=16, then high -> state returns to IDLE and all outputs are unchanged.
REQ-037 With UART_RX_MAJORITY_EN, a single-cycle inverted glitch at edge_cnt=Prescale/2 inside each data bit of 0xC3 -> P_DATA=0xC3.
REQ-038 Two back-to-back frames 0x11 and 0xEE at Prescale=8 -> two Data_Valid pulses, spaced 10 bit-times apart; RST pulsed mid-frame of a third frame -> no Data_Valid, and all outputs are 0.
